// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus a 32-step radix-2 divider, with the
// data SRAM request issued once the instruction can hand off to MEM.
module ex_stage (
  input  logic         clk,
  input  logic         reset,
  input  logic         ID_to_EX_valid,
  input  logic [142:0] IDreg_bus,
  output logic         EX_allow_in,
  input  logic         MEM_allow_in,
  output logic         EX_ready_go,
  output logic         EXreg_valid,
  output logic [106:0] EXreg_bus,
  output logic         data_sram_en,
  output logic [3:0]   data_sram_we,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata,
  output logic [39:0]  EX_bypass_bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_st_e;

  logic         ex_valid_q, ex_valid_d;
  logic [142:0] bus_q, bus_d;
  div_st_e      state_q, state_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [31:0]  r_q, r_d, q_q, q_d, dv_q, dv_d;
  logic         qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;

  logic [3:0]  alu_op, mem_we;
  logic [31:0] src1, src2, rkd_value, pc, alu_result, quo_fix, rem_fix;
  logic        rf_we, res_from_mem, is_div, sgn, ge;
  logic [4:0]  rf_waddr;
  logic [32:0] sh;

  assign {alu_op, src1, src2, rkd_value, mem_we, rf_we, res_from_mem, rf_waddr, pc} = bus_q;
  assign is_div = alu_op[3] & alu_op[2];
  assign sgn    = ~alu_op[1];

  assign EX_ready_go = ~is_div | (state_q == DONE);
  assign EX_allow_in = ~ex_valid_q | (EX_ready_go & MEM_allow_in);
  assign EXreg_valid = ex_valid_q & EX_ready_go;

  always_comb begin
    ex_valid_d = ex_valid_q;
    bus_d      = bus_q;
    if (EX_allow_in) ex_valid_d = ID_to_EX_valid;
    if (EX_allow_in & ID_to_EX_valid) bus_d = IDreg_bus;
  end

  // Divide by zero overrides the sign fix-up; magnitudes alone already give
  // the right answer for 0x80000000 / -1.
  assign quo_fix = dz_q ? 32'hFFFF_FFFF : (qneg_q ? -q_q : q_q);
  assign rem_fix = dz_q ? src1 : (rneg_q ? -r_q : r_q);

  always_comb begin
    alu_result = '0;
    case (alu_op)
      4'd0:  alu_result = src1 + src2;
      4'd1:  alu_result = src1 - src2;
      4'd2:  alu_result = {31'b0, $signed(src1) < $signed(src2)};
      4'd3:  alu_result = {31'b0, src1 < src2};
      4'd4:  alu_result = src1 & src2;
      4'd5:  alu_result = src1 | src2;
      4'd6:  alu_result = src1 ^ src2;
      4'd7:  alu_result = ~(src1 | src2);
      4'd8:  alu_result = src1 << src2[4:0];
      4'd9:  alu_result = src1 >> src2[4:0];
      4'd10: alu_result = $signed(src1) >>> src2[4:0];
      4'd11: alu_result = src2;
      default: alu_result = alu_op[0] ? rem_fix : quo_fix;
    endcase
  end

  assign sh = {r_q, q_q[31]};
  assign ge = sh >= {1'b0, dv_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    dv_d    = dv_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: if (ex_valid_q & is_div) begin
        state_d = BUSY;
        cnt_d   = '0;
        r_d     = '0;
        q_d     = (sgn & src1[31]) ? -src1 : src1;
        dv_d    = (sgn & src2[31]) ? -src2 : src2;
        qneg_d  = sgn & (src1[31] ^ src2[31]);
        rneg_d  = sgn & src1[31];
        dz_d    = (src2 == 32'd0);
      end
      BUSY: begin
        // Remainder stays below the divisor, so the subtraction fits 32 bits.
        r_d   = ge ? (sh[31:0] - dv_q) : sh[31:0];
        q_d   = {q_q[30:0], ge};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = DONE;
      end
      DONE: if (EX_ready_go & MEM_allow_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid_q <= 1'b0;
      bus_q      <= '0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      r_q        <= '0;
      q_q        <= '0;
      dv_q       <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      dz_q       <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_d;
      bus_q      <= bus_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      r_q        <= r_d;
      q_q        <= q_d;
      dv_q       <= dv_d;
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
      dz_q       <= dz_d;
    end
  end

  assign EXreg_bus       = {alu_result, rkd_value, mem_we, rf_we, res_from_mem, rf_waddr, pc};
  assign data_sram_en    = ex_valid_q & (res_from_mem | (|mem_we)) & MEM_allow_in;
  assign data_sram_we    = data_sram_en ? mem_we : 4'b0;
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = rkd_value;
  assign EX_bypass_bus   = {rf_waddr, rf_we & ex_valid_q, res_from_mem, EX_ready_go, alu_result};
endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have no parameters.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous and active-low.
REQ-004 SHALL have port ID_to_EX_valid, input, 1, ID offers an instruction.
REQ-005 SHALL have port IDreg_bus, input, 143, packed as {alu_op[142:139], src1[138:107], src2[106:75], rkd_value[74:43], mem_we[42:39], rf_we[38], res_from_mem[37], rf_waddr[36:32], pc[31:0]}.
REQ-006 SHALL have port EX_allow_in, output, 1, EX accepts from ID this cycle.
REQ-007 SHALL have port MEM_allow_in, input, 1, MEM accepts from EX this cycle.
REQ-008 SHALL have port EX_ready_go, output, 1, EX result is final.
REQ-009 SHALL have port EXreg_valid, output, 1, equal to EX_valid & EX_ready_go.
REQ-010 SHALL have port EXreg_bus, output, 107, packed as {alu_result[106:75], rkd_value[74:43], mem_we[42:39], rf_we[38], res_from_mem[37], rf_waddr[36:32], pc[31:0]}.
REQ-011 SHALL have ports data_sram_en (output, 1), data_sram_we (output, 4), data_sram_addr (output, 32) and data_sram_wdata (output, 32), forming the synchronous data RAM request.
REQ-012 SHALL have port EX_bypass_bus, output, 40, packed as {rf_waddr[39:35], rf_we&EX_valid[34], res_from_mem[33], EX_ready_go[32], alu_result[31:0]}.

Function
REQ-013 SHALL set EX_allow_in = !EX_valid | (EX_ready_go & MEM_allow_in).
REQ-014 SHALL, when EX_allow_in is high, load EX_valid <= ID_to_EX_valid, and capture IDreg_bus only when ID_to_EX_valid & EX_allow_in.
REQ-015 SHALL decode alu_op as: 0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 AND, 5 OR, 6 XOR, 7 NOR, 8 SLL, 9 SRL, 10 SRA (shift amount is src2[4:0]), 11 LUI (result = src2), 12 DIV, 13 MOD (both signed), 14 DIVU, 15 MODU.
REQ-016 SHALL compute ops 0-11 combinationally, 32-bit wrap-around, with EX_ready_go=1 in the first EX cycle.
REQ-017 SHALL implement ops 12-15 with an iterative radix-2 divider having FSM IDLE->BUSY->DONE.
REQ-018 SHALL in IDLE with EX_valid & div op: latch operand magnitudes and signs, clear counter, go to BUSY.
REQ-019 SHALL in BUSY perform one shift-subtract step per cycle and go to DONE after the 32nd step.
REQ-020 SHALL in DONE drive EX_ready_go=1 and hold the result, returning to IDLE on EX_ready_go & MEM_allow_in.
REQ-021 SHALL keep EX_ready_go=0 in IDLE (div op) and in BUSY, giving a total of 34 EX cycles when MEM never stalls.
REQ-022 SHALL make the signed quotient sign src1^src2 and the remainder sign that of src1.
REQ-023 SHALL, on divide by zero, return quotient 0xFFFFFFFF and remainder src1, regardless of signedness.
REQ-024 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, return quotient 0x80000000 and remainder 0.
REQ-025 SHALL not start a second division while the FSM is not IDLE; a new div op entering on the DONE->IDLE edge starts on the next cycle.
REQ-026 SHALL drive data_sram_en = EX_valid & (res_from_mem | |mem_we) & MEM_allow_in, exactly one cycle per memory instruction.
REQ-027 SHALL drive data_sram_we = mem_we when data_sram_en, else 0, with addr = alu_result and wdata = rkd_value.
REQ-028 SHALL hold EXreg_bus stable while EX_valid & !MEM_allow_in.

Reset
REQ-029 SHALL, on reset low, asynchronously clear EX_valid, the FSM to IDLE, the counter and the divider registers.
REQ-030 SHALL hold EXreg_valid=0, data_sram_en=0, data_sram_we=0 and EX_allow_in=1 while reset is asserted.
REQ-031 SHALL, on reset mid-division, abandon the division with no output; the first instruction after release starts fresh.

Verification
REQ-032 SHALL cover ADD 0x7FFFFFFF+1, MEM_allow_in=1 -> EXreg_valid in the same cycle, alu_result 0x80000000.
REQ-033 SHALL cover DIV -7/2 -> EX_ready_go low for 33 cycles, then quotient 0xFFFFFFFD; MOD gives 0xFFFFFFFF.
REQ-034 SHALL cover DIVU 5/0 -> 0xFFFFFFFF, MODU 5/0 -> 5, and DIV 0x80000000/-1 -> 0x80000000.
REQ-035 SHALL cover store mem_we=0xF, MEM_allow_in low for 3 cycles -> data_sram_en stays low, then one-cycle en with we=0xF, addr=alu_result, and EX_allow_in tracking each stall.
REQ-036 SHALL cover reset low at BUSY step 10 -> EXreg_valid=0, FSM in IDLE; a following ADD completes in 1 cycle.
REQ-037 SHALL cover back-to-back DIVU operations with MEM stalled 2 cycles in DONE -> result held, and the second division starts only after handoff.
